// File: rtl/sid_bus_master_if.sv
// rtl/sid_bus_master_if.sv - command, response and SID register port bundle
interface sid_bus_master_if #(
    parameter int DELAY_W = 16
);
    // Command stream
    logic               iCmdValid;
    logic               oCmdReady;
    logic               iCmdRead;
    logic [4:0]         iCmdAddr;
    logic [7:0]         iCmdData;
    logic [DELAY_W-1:0] iCmdDelay;
    // Read response stream
    logic               oRspValid;
    logic               iRspReady;
    logic [7:0]         oRspData;
    // SID register port
    logic               oWE;
    logic [4:0]         oAddr;
    logic [7:0]         oDataW;
    logic [7:0]         iDataR;
    // Status
    logic               oBusy;

    modport master (
        input  iCmdValid, iCmdRead, iCmdAddr, iCmdData, iCmdDelay,
        input  iRspReady, iDataR,
        output oCmdReady, oRspValid, oRspData, oWE, oAddr, oDataW, oBusy
    );

    modport slave (
        output iCmdValid, iCmdRead, iCmdAddr, iCmdData, iCmdDelay,
        output iRspReady, iDataR,
        input  oCmdReady, oRspValid, oRspData, oWE, oAddr, oDataW, oBusy
    );
endinterface

// File: rtl/sid_bus_master.sv
// rtl/sid_bus_master.sv - queued, clkEn-timed SID register write/read sequencer
module sid_bus_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int DELAY_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    sid_bus_master_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + 5 + 8 + DELAY_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    // Command FIFO storage: {read, addr, data, delay}
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;

    // Sequencer state
    logic [1:0]         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               read_q, read_d;
    logic [4:0]         addr_q, addr_d;
    logic [7:0]         dataw_q, dataw_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               we;

    logic [EW-1:0]      head;
    logic               head_read;
    logic [4:0]         head_addr;
    logic [7:0]         head_data;
    logic [DELAY_W-1:0] head_delay;

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.iCmdValid & bus.oCmdReady;
    assign pop   = (state_q == ST_IDLE) & !empty;

    assign head       = mem_q[rd_ptr_q];
    assign head_read  = head[EW-1];
    assign head_addr  = head[EW-2 -: 5];
    assign head_data  = head[DELAY_W+7 -: 8];
    assign head_delay = head[DELAY_W-1:0];

    assign bus.oCmdReady = !full & !rst;
    assign bus.oWE       = we;
    assign bus.oAddr     = addr_q;
    assign bus.oDataW    = dataw_q;
    assign bus.oRspValid = (state_q == ST_RSP);
    assign bus.oRspData  = rsp_data_q;
    assign bus.oBusy     = busy_q;

    // FIFO storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.iCmdRead, bus.iCmdAddr, bus.iCmdData, bus.iCmdDelay};
        end
    end

    // FIFO occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer: pop in IDLE, count clkEn ticks in WAIT, hold the response in RSP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        read_d     = read_q;
        addr_d     = addr_q;
        dataw_d    = dataw_q;
        rsp_data_d = rsp_data_q;
        we         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_WAIT;
                    cnt_d   = head_delay;
                    read_d  = head_read;
                    addr_d  = head_addr;
                    dataw_d = head_data;
                end
            end
            ST_WAIT: begin
                if (clkEn) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DELAY_W'(1);
                    end else if (read_q) begin
                        rsp_data_d = bus.iDataR;
                        state_d    = ST_RSP;
                    end else begin
                        we      = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RSP: begin
                if (bus.iRspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (count_d != '0) | (state_d != ST_IDLE);
    end

    // State registers; reset discards queued commands and any pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            read_q     <= 1'b0;
            addr_q     <= '0;
            dataw_q    <= '0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            dataw_q    <= dataw_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_sid_bus_master.sv
// tb/tb_sid_bus_master.sv - scoreboard and vector table bench for sid_bus_master
module tb_sid_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clkEn = 1'b0;
    int   ce_period = 8;

    sid_bus_master_if #(.DELAY_W(16)) bus();

    sid_bus_master #(.FIFO_DEPTH(16), .DELAY_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .clkEn (clkEn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SID read model: 0x1B returns 0xA5, other registers {3'b101, addr}
    function automatic logic [7:0] dr_model(input logic [4:0] a);
        return (a == 5'h1B) ? 8'hA5 : {3'b101, a};
    endfunction
    assign bus.iDataR = dr_model(bus.oAddr);

    typedef struct {
        logic       rd;
        logic [4:0] addr;
        logic [7:0] data;
        int         tick;
        logic [7:0] rsp;
    } exp_t;

    typedef struct {
        logic        rd;
        logic [4:0]  addr;
        logic [7:0]  data;
        logic [15:0] delay;
        logic [7:0]  exp_rsp;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ce_count = 0;
    bit   timing_chk = 1'b0;
    bit   b2b_chk = 1'b0;
    int   last_we_tick = -1;
    logic [7:0] pend_rsp = 8'h00;
    bit   prev_rv = 1'b0;
    bit   prev_ce = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // clkEn generator: one-cycle pulse every ce_period clocks
    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #1;
            div++;
            if (div >= ce_period) div = 0;
            clkEn = (div == 0);
        end
    end

    // Monitor: record accepted commands, match issues and responses against them
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_rv = 1'b0;
            prev_ce = 1'b0;
            last_we_tick = -1;
        end else begin
            if (clkEn) ce_count++;
            if (bus.iCmdValid && bus.oCmdReady) begin
                e.rd   = bus.iCmdRead;
                e.addr = bus.iCmdAddr;
                e.data = bus.iCmdData;
                e.tick = timing_chk ? ce_count + int'(bus.iCmdDelay) + 1 : -1;
                e.rsp  = pend_rsp;
                sb.push_back(e);
            end
            if (bus.oWE) begin
                check("we_with_clken", clkEn, 1'b1);
                if (sb.size() == 0) begin
                    check("unexpected_we", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check("we_on_write_cmd", e.rd, 1'b0);
                    check("we_addr", bus.oAddr, e.addr);
                    check("we_data", bus.oDataW, e.data);
                    if (e.tick >= 0) check("we_tick", ce_count, e.tick);
                end
                if (b2b_chk && last_we_tick >= 0) check("b2b_tick", ce_count, last_we_tick + 1);
                last_we_tick = ce_count;
            end
            if (bus.oRspValid && !prev_rv) begin
                check("rsp_after_clken", prev_ce, 1'b1);
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 0, 1);
                end else begin
                    check("rsp_on_read_cmd", sb[0].rd, 1'b1);
                    check("rsp_addr", bus.oAddr, sb[0].addr);
                    if (sb[0].tick >= 0) check("rsp_tick", ce_count, sb[0].tick);
                end
            end
            if (bus.oRspValid && bus.iRspReady && sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_data", bus.oRspData, e.rsp);
            end
            prev_rv = bus.oRspValid;
            prev_ce = clkEn;
        end
    end

    // Wait until the cycle right after a clkEn pulse so no tick hits accept/pop cycles
    task automatic align();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (clkEn) break;
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one command and hold it until accepted; valid is left high for chaining
    task automatic push(input logic rd, input logic [4:0] a, input logic [7:0] d,
                        input logic [15:0] dly, input logic [7:0] rsp);
        bit ok = 1'b0;
        bus.iCmdValid = 1'b1;
        bus.iCmdRead  = rd;
        bus.iCmdAddr  = a;
        bus.iCmdData  = d;
        bus.iCmdDelay = dly;
        pend_rsp      = rsp;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.oCmdReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.oBusy) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 5'h18, 8'h0F, 16'd0, 8'h00};
        vecs[1] = '{1'b0, 5'h04, 8'h41, 16'd3, 8'h00};
        vecs[2] = '{1'b1, 5'h1B, 8'h00, 16'd0, 8'hA5};
        vecs[3] = '{1'b1, 5'h07, 8'h33, 16'd2, 8'hA7};
        vecs[4] = '{1'b0, 5'h1F, 8'hFF, 16'd1, 8'h00};
        vecs[5] = '{1'b1, 5'h00, 8'h00, 16'd0, 8'hA0};

        bus.iCmdValid = 1'b0;
        bus.iCmdRead  = 1'b0;
        bus.iCmdAddr  = 5'h00;
        bus.iCmdData  = 8'h00;
        bus.iCmdDelay = 16'h0000;
        bus.iRspReady = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.oCmdReady, 1'b0);
        check("rst_we", bus.oWE, 1'b0);
        check("rst_addr", bus.oAddr, 5'h00);
        check("rst_dataw", bus.oDataW, 8'h00);
        check("rst_rsp_valid", bus.oRspValid, 1'b0);
        check("rst_rsp_data", bus.oRspData, 8'h00);
        check("rst_busy", bus.oBusy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.oCmdReady, 1'b1);

        // Single commands from the vector table, each with exact tick timing
        timing_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            align();
            push(vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].exp_rsp);
            bus.iCmdValid = 1'b0;
            drain(200);
            check("vec_busy_idle", bus.oBusy, 1'b0);
            check("vec_addr_hold", bus.oAddr, vecs[i].addr);
            if (!vecs[i].rd) check("vec_dataw_hold", bus.oDataW, vecs[i].data);
        end
        timing_chk = 1'b0;

        // Back-to-back zero-delay writes: one issue per clkEn
        ce_period = 3;
        b2b_chk = 1'b1;
        last_we_tick = -1;
        for (int i = 0; i < 5; i++) push(1'b0, 5'(i + 8), 8'(8'h90 + i), 16'd0, 8'h00);
        bus.iCmdValid = 1'b0;
        drain(200);
        b2b_chk = 1'b0;
        ce_period = 8;

        // FIFO full: 17 gapless commands fill the FIFO plus the sequencer
        for (int i = 0; i < 17; i++) push(1'b0, 5'(i), 8'(8'hC0 + i), 16'd100, 8'h00);
        bus.iCmdValid = 1'b0;
        @(negedge clk);
        check("full_ready_low", bus.oCmdReady, 1'b0);
        check("full_busy", bus.oBusy, 1'b1);
        drain(16000);
        check("full_ready_back", bus.oCmdReady, 1'b1);

        // Response stall: second read must wait for the first handshake
        bus.iRspReady = 1'b0;
        push(1'b1, 5'h1B, 8'h00, 16'd0, 8'hA5);
        push(1'b1, 5'h03, 8'h00, 16'd0, 8'hA3);
        bus.iCmdValid = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (bus.oRspValid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("stall_rsp_seen", seen, 1'b1);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("stall_valid_held", bus.oRspValid, 1'b1);
            check("stall_data_stable", bus.oRspData, 8'hA5);
            check("stall_no_second_issue", bus.oAddr, 5'h1B);
        end
        @(posedge clk);
        #1;
        bus.iRspReady = 1'b1;
        drain(200);

        // Reset in the middle of a WAIT
        align();
        push(1'b0, 5'h01, 8'h55, 16'd5, 8'h00);
        bus.iCmdValid = 1'b0;
        begin
            int start = ce_count;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (ce_count >= start + 2) break;
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", bus.oWE, 1'b0);
        check("mid_rst_ready", bus.oCmdReady, 1'b0);
        check("mid_rst_busy", bus.oBusy, 1'b0);
        check("mid_rst_addr", bus.oAddr, 5'h00);
        check("mid_rst_dataw", bus.oDataW, 8'h00);
        check("mid_rst_rsp_valid", bus.oRspValid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Any oWE in this window hits the monitor with an empty scoreboard
        repeat (100) @(posedge clk);
        #1;
        check("post_rst_idle", bus.oBusy, 1'b0);
        timing_chk = 1'b1;
        align();
        push(1'b0, 5'h02, 8'h66, 16'd1, 8'h00);
        bus.iCmdValid = 1'b0;
        drain(200);
        check("post_rst_addr", bus.oAddr, 5'h02);
        check("post_rst_dataw", bus.oDataW, 8'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/sid_bus_master.md
# sid_bus_master

Host-side bus sequencer that drives the SID register port (write enable, 5-bit address, 8-bit write data, 8-bit read data) from a queued command stream. Each command is a timed register write or read, released on the 1 MHz `clkEn` grid after a programmable wait, so a player core or UART bridge can stream register dumps with cycle-accurate spacing. Read results are returned on a valid/ready response channel.

## Interface
- `FIFO_DEPTH`, 16, command FIFO entries; power of two, ≥2
- `DELAY_W`, 16, width of per-command delay field in `clkEn` ticks
- `clk` in 1, master clock
- `rst` in 1, asynchronous, active-high reset
- `clkEn` in 1, 1 MHz enable; one `clk` cycle wide
- `iCmdValid` in 1, command offered
- `oCmdReady` out 1, command accepted when `iCmdValid & oCmdReady`
- `iCmdRead` in 1, 1 = register read, 0 = register write
- `iCmdAddr` in 5, SID register address
- `iCmdData` in 8, write data (ignored for reads)
- `iCmdDelay` in `DELAY_W`, `clkEn` ticks to wait before issuing
- `oRspValid` out 1, read data available
- `iRspReady` in 1, response consumed when `oRspValid & iRspReady`
- `oRspData` out 8, read data
- `oWE` out 1, SID write enable
- `oAddr` out 5, SID address
- `oDataW` out 8, SID write data
- `iDataR` in 8, SID read data (combinational from `oAddr`)
- `oBusy` out 1, FIFO non-empty or FSM not IDLE

## Operation
- Reset values: `oCmdReady` 0 while `rst` high, `oWE` 0, `oAddr` 0, `oDataW` 0, `oRspValid` 0, `oRspData` 0, `oBusy` 0; FIFO empty, FSM IDLE, counter 0.
- FIFO stores {read, addr, data, delay}; `oCmdReady = !full & !rst`. Push when full is impossible; simultaneous push+pop when not full both occur, count unchanged.
- FSM states IDLE, WAIT, RSP:
  - IDLE: if FIFO non-empty, pop head, load counter with delay, latch `oAddr`/`oDataW` from entry, go WAIT.
  - WAIT: on a `clkEn` cycle with counter ≠ 0, decrement. On a `clkEn` cycle with counter = 0, issue: write → `oWE`=1 this cycle only, go IDLE; read → capture `iDataR` into `oRspData` this cycle, go RSP.
  - RSP: assert `oRspValid`; on `iRspReady` clear it and go IDLE.
- Read issue requires response register free; since FSM blocks in RSP until consumed, only one read is outstanding.
- `oAddr`/`oDataW` hold the last issued command's values until the next pop (register-address stability for downstream reads).
- Delay 0xFFFF is a plain count; no wrap or special case.
- Reset mid-operation: all state cleared asynchronously; `oWE` drops immediately; queued commands and pending response discarded.

## Timing
- Command accepted at cycle N → FIFO head visible N+1 → popped by IDLE at N+1 at earliest → WAIT from N+2.
- Issue occurs on the (delay+1)-th `clkEn` cycle strictly after the pop cycle; a `clkEn` coincident with the pop cycle does not count.
- `oWE` high exactly one `clk` cycle, always coincident with `clkEn`=1.
- Read: `oRspValid` rises the cycle after the issuing `clkEn`; `oRspData` equals `iDataR` sampled on that `clkEn` cycle.
- Back-to-back commands with delay 0: one issue per `clkEn` at most; throughput one register access per `clkEn` when `clkEn` period ≥ 2 `clk`.
- `oBusy` registered; falls the cycle after the final write issue with FIFO empty, or after final response handshake.

## Test plan
- Write, delay 0: push {W,0x18,0x0F,0}, `clkEn` every 8 clk → `oWE` pulses once on first `clkEn` after pop, `oAddr`=0x18, `oDataW`=0x0F; `oBusy` then 0.
- Write, delay 3: push {W,0x04,0x41,3} → `oWE` on 4th `clkEn` after pop, none earlier; exactly one pulse.
- Read: push {R,0x1B,-,0}, `iDataR` model returns 0xA5 at 0x1B, `iRspReady`=1 → `oRspValid` one cycle, `oRspData`=0xA5, `oWE` never asserted.
- FIFO full: push 17 commands with delay 100 without gaps → `oCmdReady` drops after FIFO fills; all accepted commands issue in order with correct addr/data.
- Response stall: two reads queued, `iRspReady`=0 for 50 cycles → `oRspValid` held, data stable at first value, second read not issued until handshake.
- Reset mid-WAIT: push {W,0x01,0x55,5}, assert `rst` after 2 `clkEn` → all outputs at reset values, no `oWE` ever pulses; after release, new command issues normally.
